crash_handler: RTL and testbench
================================

Name: crash_handler

Overview:
- Consumes the combinational colision flag from the car-overlap checker and drives the player car's crash response.
- Response sequence: lock controls, spin the sprite, decrement lives, respawn at road centre, then a blinking invulnerability window.
- Sits between the collision checker and the player-car movement/sprite logic; the game FSM sees lives and game_over.

Parameters:
LIVES_INIT, 3, lives loaded at reset and on restart (2-bit field, 1..3)
SPIN_FRAMES, 48, frame ticks spent in SPIN
INVULN_FRAMES, 96, frame ticks spent in BLINK
BLINK_SHIFT, 2, sprite_visible toggles every 2^BLINK_SHIFT frame ticks in BLINK
ROAD_CENTER_X, 8'd120, x coordinate presented on respawn_x

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per video frame
colision  in  1  overlap flag from the collision checker, sampled every clk
restart  in  1  one-cycle pulse from the game FSM
crashed  out  1  high in SPIN
control_lock  out  1  high in SPIN and GAME_OVER; movement logic ignores steering and forces speed 0
spin_phase  out  2  sprite rotation index, 0..3
sprite_visible  out  1  player sprite enable
respawn  out  1  one-cycle pulse; movement logic loads respawn_x
respawn_x  out  8  constant ROAD_CENTER_X
lives  out  2  remaining lives
game_over  out  1  high in GAME_OVER

Behaviour:
- Reset (rst_n low, async), all registers:
  - state=NORMAL, lives=LIVES_INIT, frame counter=0
  - crashed=0, control_lock=0, spin_phase=0, sprite_visible=1, respawn=0, game_over=0
- All outputs are registered; respawn_x is a constant.
- States are NORMAL, SPIN, BLINK and GAME_OVER. Frame counter is 8 bits and counts frame_tick only.
- NORMAL:
  - colision=1 at a clk edge -> SPIN next cycle; lives decremented, frame counter=0, spin_phase=0.
  - A frame_tick in the same cycle is not counted.
- SPIN:
  - Each frame_tick: frame counter +1; spin_phase +1 mod 4 (wraps 3->0).
  - colision is ignored.
  - Counter reaching SPIN_FRAMES:
    - If lives==0 -> GAME_OVER; no respawn pulse.
    - Otherwise -> BLINK with respawn=1 for exactly that one cycle; counter=0, spin_phase=0.
- BLINK:
  - colision is ignored (invulnerable).
  - sprite_visible = ~counter[BLINK_SHIFT].
  - Counter reaching INVULN_FRAMES -> NORMAL with sprite_visible=1.
  - If colision is still asserted on the NORMAL entry cycle, the next edge starts a new crash. This is intended: a car left overlapping must crash again.
- GAME_OVER:
  - control_lock=1, game_over=1, sprite_visible=1; holds until restart.
- restart (any state, highest priority, synchronous):
  - Next state NORMAL, lives=LIVES_INIT, counter=0.
  - crashed, control_lock, game_over and respawn all 0.
  - Beats colision in the same cycle.
- Lives never underflow: decrement only from NORMAL, and NORMAL is unreachable with lives==0 except via restart.
- Async reset mid-SPIN or mid-BLINK returns to reset values immediately; no respawn pulse is emitted.
- Counter compare uses an equality test on the post-increment value; the widths of SPIN_FRAMES and INVULN_FRAMES must fit in 8 bits.

Decomposition:
- Shared game package holds:
  - state encoding (NORMAL=0, SPIN=1, BLINK=2, GAME_OVER=3)
  - ROAD_CENTER_X and the car dimension constants (16x32), shared with the collision checker and sprite logic
- One natural sub-module: frame_counter.
  - Ports: clear, enable = frame_tick, 8-bit count, terminal-match output for a given limit.
  - Instantiated once; the FSM selects the limit by state.
- Rest of the block: a single FSM plus output registers.

Test Plan:
- Reset then idle with colision=0 for 10 frame ticks -> lives=3, all flags 0, sprite_visible=1, spin_phase=0.
- Crash and spin:
  - Stimulus: colision=1 for 1 cycle in NORMAL.
  - Next cycle: crashed=1, control_lock=1, lives=2.
  - After 48 frame ticks: respawn high for exactly 1 cycle with respawn_x=120; state BLINK; spin_phase cycles 0,1,2,3,0 across ticks.
- BLINK window:
  - Hold colision=1 throughout BLINK -> no lives change.
  - sprite_visible toggles every 4 ticks.
  - After 96 ticks, state NORMAL; colision still high -> second crash, lives=1.
- Three crashes from reset:
  - After the third SPIN completes: game_over=1, control_lock=1, lives=0, no respawn pulse.
  - Further colision has no effect.
  - restart pulse -> lives=3, NORMAL, game_over=0.
- Simultaneous events:
  - colision and frame_tick in the same NORMAL cycle -> SPIN entered with counter=0.
  - restart and colision together in NORMAL -> stays NORMAL, lives=3.
- Async reset:
  - Drop rst_n at SPIN tick 20 -> outputs return to reset values without waiting for clk.
  - After release, first clk edge sees NORMAL with lives=3.

Source files
------------

// File: rtl/crash_handler_pkg.sv
// Shared game constants and crash-response state encoding.
// Imported by the crash handler, collision checker and sprite logic.
package crash_handler_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL    = 2'd0,
    ST_SPIN      = 2'd1,
    ST_BLINK     = 2'd2,
    ST_GAME_OVER = 2'd3
  } crash_state_t;

  localparam logic [1:0] LIVES_INIT    = 2'd3;
  localparam logic [7:0] SPIN_FRAMES   = 8'd48;
  localparam logic [7:0] INVULN_FRAMES = 8'd96;
  localparam int         BLINK_SHIFT   = 2;
  localparam logic [7:0] ROAD_CENTER_X = 8'd120;

  localparam int CAR_W = 16;
  localparam int CAR_H = 32;

endpackage

// File: rtl/crash_handler_if.sv
// Handshake bundle between collision checker, game FSM and car logic.
// slave is the crash handler side; master drives the event inputs.
interface crash_handler_if;

  logic       frame_tick;
  logic       colision;
  logic       restart;
  logic       crashed;
  logic       control_lock;
  logic [1:0] spin_phase;
  logic       sprite_visible;
  logic       respawn;
  logic [7:0] respawn_x;
  logic [1:0] lives;
  logic       game_over;

  modport slave (
    input  frame_tick,
    input  colision,
    input  restart,
    output crashed,
    output control_lock,
    output spin_phase,
    output sprite_visible,
    output respawn,
    output respawn_x,
    output lives,
    output game_over
  );

  modport master (
    output frame_tick,
    output colision,
    output restart,
    input  crashed,
    input  control_lock,
    input  spin_phase,
    input  sprite_visible,
    input  respawn,
    input  respawn_x,
    input  lives,
    input  game_over
  );

endinterface

// File: rtl/crash_handler_frame_counter.sv
// 8-bit frame-tick counter with clear and a terminal match
// on the post-increment value against a caller-chosen limit.
module crash_handler_frame_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic [7:0] i_limit,
  output logic [7:0] o_count,
  output logic       o_match
);

  logic [7:0] r_count;
  logic [7:0] w_inc;

  assign w_inc   = r_count + 8'd1;
  assign o_match = i_enable & (w_inc == i_limit);
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (i_clear) begin
      r_count <= 8'd0;
    end else if (i_enable) begin
      r_count <= w_inc;
    end
  end

endmodule

// File: rtl/crash_handler.sv
// Player-car crash response: lock, spin, lose a life, respawn,
// then a blinking invulnerability window or game over.
module crash_handler
  import crash_handler_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  crash_handler_if.slave bus
);

  crash_state_t r_state;
  crash_state_t w_state_nxt;

  logic [1:0] r_lives;
  logic [1:0] r_spin;
  logic       r_crashed;
  logic       r_lock;
  logic       r_vis;
  logic       r_respawn;
  logic       r_go;

  logic [1:0] w_lives_nxt;
  logic [1:0] w_spin_nxt;
  logic       w_crashed_nxt;
  logic       w_lock_nxt;
  logic       w_vis_nxt;
  logic       w_respawn_nxt;
  logic       w_go_nxt;

  logic       w_clr;
  logic       w_match;
  logic [7:0] w_limit;
  logic [7:0] w_cnt;
  logic [7:0] w_cnt_inc;

  assign w_limit   = (r_state == ST_SPIN) ? SPIN_FRAMES
                                          : INVULN_FRAMES;
  assign w_cnt_inc = w_cnt + 8'd1;

  crash_handler_frame_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_clr),
    .i_enable (bus.frame_tick),
    .i_limit  (w_limit),
    .o_count  (w_cnt),
    .o_match  (w_match)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_NORMAL;
      r_lives   <= LIVES_INIT;
      r_spin    <= 2'd0;
      r_crashed <= 1'b0;
      r_lock    <= 1'b0;
      r_vis     <= 1'b1;
      r_respawn <= 1'b0;
      r_go      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lives   <= w_lives_nxt;
      r_spin    <= w_spin_nxt;
      r_crashed <= w_crashed_nxt;
      r_lock    <= w_lock_nxt;
      r_vis     <= w_vis_nxt;
      r_respawn <= w_respawn_nxt;
      r_go      <= w_go_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lives_nxt   = r_lives;
    w_spin_nxt    = r_spin;
    w_respawn_nxt = 1'b0;
    w_vis_nxt     = 1'b1;
    w_clr         = 1'b0;

    unique case (r_state)
      ST_NORMAL: begin
        // counter held at zero so a tick on the crash edge is not counted
        w_clr = 1'b1;
        if (bus.colision) begin
          w_state_nxt = ST_SPIN;
          w_lives_nxt = r_lives - 2'd1;
          w_spin_nxt  = 2'd0;
        end
      end
      ST_SPIN: begin
        if (w_match) begin
          w_clr      = 1'b1;
          w_spin_nxt = 2'd0;
          if (r_lives == 2'd0) begin
            w_state_nxt = ST_GAME_OVER;
          end else begin
            w_state_nxt   = ST_BLINK;
            w_respawn_nxt = 1'b1;
          end
        end else if (bus.frame_tick) begin
          w_spin_nxt = r_spin + 2'd1;
        end
      end
      ST_BLINK: begin
        if (w_match) begin
          w_clr       = 1'b1;
          w_state_nxt = ST_NORMAL;
        end else if (bus.frame_tick) begin
          w_vis_nxt = ~w_cnt_inc[BLINK_SHIFT];
        end else begin
          w_vis_nxt = ~w_cnt[BLINK_SHIFT];
        end
      end
      ST_GAME_OVER: begin
        w_clr = 1'b1;
      end
      default: begin
        w_clr       = 1'b1;
        w_state_nxt = ST_NORMAL;
      end
    endcase

    if (bus.restart) begin
      w_state_nxt   = ST_NORMAL;
      w_lives_nxt   = LIVES_INIT;
      w_spin_nxt    = 2'd0;
      w_respawn_nxt = 1'b0;
      w_vis_nxt     = 1'b1;
      w_clr         = 1'b1;
    end

    w_crashed_nxt = (w_state_nxt == ST_SPIN);
    w_lock_nxt    = (w_state_nxt == ST_SPIN) ||
                    (w_state_nxt == ST_GAME_OVER);
    w_go_nxt      = (w_state_nxt == ST_GAME_OVER);
  end

  assign bus.crashed        = r_crashed;
  assign bus.control_lock   = r_lock;
  assign bus.spin_phase     = r_spin;
  assign bus.sprite_visible = r_vis;
  assign bus.respawn        = r_respawn;
  assign bus.respawn_x      = ROAD_CENTER_X;
  assign bus.lives          = r_lives;
  assign bus.game_over      = r_go;

endmodule

// File: tb/tb_crash_handler.sv
// Scoreboard bench for crash_handler: stimulus queues expected
// output snapshots tagged by cycle; a negedge monitor checks them.
module tb_crash_handler;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crash_handler_if u_if ();

  crash_handler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  typedef struct {
    int          tag;
    string       nm;
    logic [16:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [16:0] w_act;
  assign w_act = {u_if.crashed, u_if.control_lock, u_if.spin_phase,
                  u_if.sprite_visible, u_if.respawn, u_if.respawn_x,
                  u_if.lives, u_if.game_over};

  // fields: crashed lock spin vis respawn x lives game_over
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].tag <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      if (e.tag != cyc) begin
        $display("FAIL %s: sample missed (tag %0d at cycle %0d)",
                 e.nm, e.tag, cyc);
      end else if (w_act !== e.v) begin
        $display("FAIL %s: got cr%b lk%b sp%0d vis%b rsp%b x%0d lv%0d go%b want cr%b lk%b sp%0d vis%b rsp%b x%0d lv%0d go%b",
                 e.nm, w_act[16], w_act[15], w_act[14:13], w_act[12],
                 w_act[11], w_act[10:3], w_act[2:1], w_act[0],
                 e.v[16], e.v[15], e.v[14:13], e.v[12],
                 e.v[11], e.v[10:3], e.v[2:1], e.v[0]);
      end else begin
        n_pass++;
      end
    end
  end

  task automatic expect_o(input string nm, input logic cr,
                          input logic lk, input logic [1:0] sp,
                          input logic vs, input logic rp,
                          input logic [1:0] lv, input logic go);
    exp_t e;
    e.tag = cyc;
    e.nm  = nm;
    e.v   = {cr, lk, sp, vs, rp, 8'd120, lv, go};
    sb.push_back(e);
  endtask

  task automatic step(input logic ft, input logic col, input logic rs);
    u_if.frame_tick = ft;
    u_if.colision   = col;
    u_if.restart    = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic col);
    step(1'b1, col, 1'b0);
    step(1'b0, col, 1'b0);
  endtask

  initial begin
    rst_n           = 1'b0;
    u_if.frame_tick = 1'b0;
    u_if.colision   = 1'b0;
    u_if.restart    = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    expect_o("reset", 0, 0, 2'd0, 1, 0, 2'd3, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) tick(1'b0);
    expect_o("idle", 0, 0, 2'd0, 1, 0, 2'd3, 0);

    step(1'b0, 1'b1, 1'b0);
    expect_o("crash1", 1, 1, 2'd0, 1, 0, 2'd2, 0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 48; i++) begin
      tick(1'b0);
      if (i <= 4)
        expect_o($sformatf("spin_ph%0d", i), 1, 1, 2'(i % 4),
                 1, 0, 2'd2, 0);
    end
    step(1'b1, 1'b0, 1'b0);
    expect_o("respawn1", 0, 0, 2'd0, 1, 1, 2'd2, 0);
    step(1'b0, 1'b1, 1'b0);
    expect_o("respawn_1cyc", 0, 0, 2'd0, 1, 0, 2'd2, 0);

    for (int i = 1; i < 96; i++) begin
      tick(1'b1);
      if (i == 3) expect_o("blink3", 0, 0, 2'd0, 1, 0, 2'd2, 0);
      if (i == 4) expect_o("blink4", 0, 0, 2'd0, 0, 0, 2'd2, 0);
      if (i == 7) expect_o("blink7", 0, 0, 2'd0, 0, 0, 2'd2, 0);
      if (i == 8) expect_o("blink8", 0, 0, 2'd0, 1, 0, 2'd2, 0);
      if (i == 95) expect_o("blink95", 0, 0, 2'd0, 0, 0, 2'd2, 0);
    end
    step(1'b1, 1'b1, 1'b0);
    expect_o("blink_end", 0, 0, 2'd0, 1, 0, 2'd2, 0);
    step(1'b0, 1'b1, 1'b0);
    expect_o("recrash", 1, 1, 2'd0, 1, 0, 2'd1, 0);

    for (int i = 1; i < 48; i++) tick(1'b0);
    step(1'b1, 1'b0, 1'b0);
    expect_o("respawn2", 0, 0, 2'd0, 1, 1, 2'd1, 0);
    for (int i = 1; i < 96; i++) tick(1'b0);
    step(1'b1, 1'b0, 1'b0);
    expect_o("normal2", 0, 0, 2'd0, 1, 0, 2'd1, 0);

    step(1'b1, 1'b1, 1'b0);
    expect_o("crash3_tick", 1, 1, 2'd0, 1, 0, 2'd0, 0);
    for (int i = 1; i < 48; i++) tick(1'b0);
    expect_o("spin3_47", 1, 1, 2'd3, 1, 0, 2'd0, 0);
    step(1'b1, 1'b0, 1'b0);
    expect_o("game_over", 0, 1, 2'd0, 1, 0, 2'd0, 1);
    for (int i = 0; i < 4; i++) tick(1'b1);
    expect_o("go_hold", 0, 1, 2'd0, 1, 0, 2'd0, 1);

    step(1'b0, 1'b0, 1'b1);
    expect_o("restart", 0, 0, 2'd0, 1, 0, 2'd3, 0);
    step(1'b0, 1'b1, 1'b1);
    expect_o("restart_vs_col", 0, 0, 2'd0, 1, 0, 2'd3, 0);
    step(1'b0, 1'b0, 1'b0);
    expect_o("after_restart", 0, 0, 2'd0, 1, 0, 2'd3, 0);

    step(1'b0, 1'b1, 1'b0);
    expect_o("crash4", 1, 1, 2'd0, 1, 0, 2'd2, 0);
    for (int i = 1; i < 20; i++) tick(1'b0);
    expect_o("spin4_19", 1, 1, 2'd3, 1, 0, 2'd2, 0);
    step(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    expect_o("async_reset", 0, 0, 2'd0, 1, 0, 2'd3, 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    expect_o("post_reset", 0, 0, 2'd0, 1, 0, 2'd3, 0);
    step(1'b0, 1'b1, 1'b0);
    expect_o("post_reset_crash", 1, 1, 2'd0, 1, 0, 2'd2, 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      $display("FAIL %s: never sampled (tag %0d, cycle %0d)",
               e.nm, e.tag, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
